// File: rtl/mealy_101_detector.sv
// Serial 1-0-1 sequence detector, Mealy style.
// Y rises in the same cycle as the closing '1' and is never registered.
// OVERLAP selects whether that closing '1' may open the next match.
//
// state | meaning
// ------+-----------------------------------
// S0    | no progress toward a match
// S1    | last bit seen was 1
// S10   | last two bits seen were 1 then 0
module mealy_101_detector #(
  parameter bit OVERLAP = 1'b1
) (
  output logic Y,
  input  logic CLK,
  input  logic RST,
  input  logic din
);

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S1  = 2'b01,
    S10 = 2'b10
  } state_t;

  state_t state;

  // Pattern tracking; the spare encoding falls back to S0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S0;
    end else begin
      case (state)
        S0:      state <= din ? S1 : S0;
        S1:      state <= din ? S1 : S10;
        S10:     state <= (din && OVERLAP) ? S1 : S0;
        default: state <= S0;
      endcase
    end
  end

  // Gating with RST keeps Y low while the state is still unknown at power-up.
  assign Y = ~RST & (state == S10) & din;

endmodule

// File: tb/tb_mealy_101_detector.sv
// Bench for mealy_101_detector: two instances (overlap on/off) share the
// input stream; a bit-history reference model predicts Y for each.
module tb_mealy_101_detector;

  logic clk;
  logic rst;
  logic din;
  logic y_ov;
  logic y_no;

  int checks = 0;
  int errors = 0;

  // Reference model: count of bits seen since reset (and, for the
  // non-overlapping variant, since the last match) plus the last two bits.
  int       cnt_ov = 0;
  int       cnt_no = 0;
  bit [1:0] hist   = 2'b00;

  mealy_101_detector #(.OVERLAP(1'b1)) u_dut_ov (
    .Y   (y_ov),
    .CLK (clk),
    .RST (rst),
    .din (din)
  );

  mealy_101_detector #(.OVERLAP(1'b0)) u_dut_no (
    .Y   (y_no),
    .CLK (clk),
    .RST (rst),
    .din (din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // A match: not in reset, previous two valid bits were 1,0 and din is 1.
  function automatic bit exp_match(input int cnt, input bit r, input bit d);
    return !r && (cnt >= 2) && (hist == 2'b10) && d;
  endfunction

  task automatic model_edge(input bit r, input bit d);
    bit m_no;
    if (r) begin
      cnt_ov = 0;
      cnt_no = 0;
    end else begin
      m_no = exp_match(cnt_no, r, d);
      cnt_ov++;
      cnt_no = m_no ? 0 : cnt_no + 1;
      hist = {hist[0], d};
    end
  endtask

  // Drive one bit, check both outputs mid-cycle, then advance the model.
  task automatic step(input bit r, input bit d, input string tag);
    rst = r;
    din = d;
    @(negedge clk);
    check_bit({tag, "/ov"}, y_ov, exp_match(cnt_ov, r, d));
    check_bit({tag, "/no"}, y_no, exp_match(cnt_no, r, d));
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic run_stream(input string tag, input bit bits[$]);
    foreach (bits[i]) step(1'b0, bits[i], $sformatf("%s[%0d]", tag, i + 1));
  endtask

  int hits_ov;
  int hits_no;

  initial begin
    rst = 1'b1;
    din = 1'b1;
    #2;
    check_bit("powerup_rst_gate/ov", y_ov, 1'b0);
    check_bit("powerup_rst_gate/no", y_no, 1'b0);
    @(posedge clk);
    #1;

    // Reset held with din toggling, then release with din low.
    step(1'b1, 1'b0, "rst_hold0");
    step(1'b1, 1'b1, "rst_hold1");
    step(1'b0, 1'b0, "rst_release");
    step(1'b0, 1'b0, "rst_release2");

    // Overlap stream: overlapping instance must fire on bits 3,6,8,11.
    step(1'b1, 1'b0, "rst_a");
    hits_ov = 0;
    hits_no = 0;
    begin
      bit s[$] = '{1,0,1,1,0,1,0,1,1,0,1};
      bit want_ov[$] = '{0,0,1,0,0,1,0,1,0,0,1};
      foreach (s[i]) begin
        rst = 1'b0;
        din = s[i];
        @(negedge clk);
        check_bit($sformatf("ovl_stream[%0d]", i + 1), y_ov, want_ov[i]);
        check_bit($sformatf("ovl_stream_model[%0d]", i + 1), y_no,
                  exp_match(cnt_no, 1'b0, s[i]));
        @(posedge clk);
        model_edge(1'b0, s[i]);
        #1;
      end
    end

    // Non-overlap stream: non-overlapping instance fires on bits 3 and 7 only.
    step(1'b1, 1'b0, "rst_b");
    begin
      bit s[$] = '{1,0,1,0,1,0,1};
      bit want_no[$] = '{0,0,1,0,0,0,1};
      foreach (s[i]) begin
        rst = 1'b0;
        din = s[i];
        @(negedge clk);
        check_bit($sformatf("novl_stream[%0d]", i + 1), y_no, want_no[i]);
        check_bit($sformatf("novl_stream_ov[%0d]", i + 1), y_ov, i >= 2 && s[i]);
        @(posedge clk);
        model_edge(1'b0, s[i]);
        #1;
      end
    end

    // Mealy timing: reach S10, raise din mid-cycle, watch Y follow then drop.
    step(1'b1, 1'b0, "rst_c");
    step(1'b0, 1'b1, "mealy_1");
    step(1'b0, 1'b0, "mealy_0");
    rst = 1'b0;
    din = 1'b0;
    #1;
    check_bit("mealy_pre/ov", y_ov, 1'b0);
    @(negedge clk);
    din = 1'b1;
    #1;
    check_bit("mealy_rise/ov", y_ov, 1'b1);
    check_bit("mealy_rise/no", y_no, 1'b1);
    @(posedge clk);
    model_edge(1'b0, 1'b1);
    #1;
    check_bit("mealy_fall/ov", y_ov, 1'b0);
    check_bit("mealy_fall/no", y_no, 1'b0);
    // In S10 with din high, RST must gate Y immediately.
    step(1'b0, 1'b0, "gate_0");
    rst = 1'b1;
    din = 1'b1;
    #1;
    check_bit("rst_gate/ov", y_ov, 1'b0);
    @(posedge clk);
    model_edge(1'b1, 1'b1);
    #1;

    // Reset mid-pattern: 1,0, reset, 1 never reports.
    step(1'b0, 1'b1, "midrst_1");
    step(1'b0, 1'b0, "midrst_0");
    step(1'b1, 1'b0, "midrst_rst");
    step(1'b0, 1'b1, "midrst_after");
    check_bit("midrst_hist/ov", y_ov, 1'b0);

    // Noise immunity streams.
    step(1'b1, 1'b0, "rst_d");
    run_stream("noise_000", '{0,0,0});
    step(1'b1, 1'b0, "rst_e");
    run_stream("noise_1111", '{1,1,1,1});
    step(1'b1, 1'b0, "rst_f");
    run_stream("noise_1001", '{1,0,0,1});
    step(1'b1, 1'b0, "rst_g");
    run_stream("noise_0110", '{0,1,1,0});

    // Random stream with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) == 0), $urandom_range(0, 1) == 1,
           $sformatf("rand[%0d]", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
